arc4_crack_ctrl: RTL and testbench

- Parametrised brute-force key search controller that sits above the ARC4 decrypt core.
- Launches one decrypt per candidate key and snoops the core's plaintext writes.
- Rejects a key as soon as any plaintext byte falls outside the configured character class; otherwise reports it as found.
- Adds what the single-core cracker lacks: runtime base/stride for multi-core key-space partitioning, a stop input, early abort of doomed decrypts, and a tried-key counter.

---
 rtl/arc4_crack_pkg.sv | 28 ++
 rtl/arc4_pt_checker.sv | 43 ++++
 rtl/arc4_crack_ctrl.sv | 135 +++++++++++++
 tb/tb_arc4_crack_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_crack_pkg.sv
// Shared types and helpers for the ARC4 key search controller.
// Holds the FSM encoding and the plaintext character-class test.
package arc4_crack_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_CHECK
    } crack_state_t;

    localparam logic [7:0] SPACE_CHAR = 8'd32;
    localparam logic [7:0] LEN_ADDR   = 8'd0;

    function automatic logic is_bad_byte(
        input logic [7:0] b,
        input logic [7:0] lo,
        input logic [7:0] hi,
        input logic       allow_space
    );
        logic in_range;
        logic is_space;
        in_range = (b >= lo) && (b <= hi);
        is_space = allow_space && (b == SPACE_CHAR);
        return !(in_range || is_space);
    endfunction

endpackage

// File: rtl/arc4_pt_checker.sv
// Snoops core plaintext writes and flags the first out-of-class byte.
// The flag is sticky per candidate; abort pulses only on the first hit.
module arc4_pt_checker
    import arc4_crack_pkg::*;
#(
    parameter logic [7:0] CHAR_LO     = 8'd97,
    parameter logic [7:0] CHAR_HI     = 8'd122,
    parameter int         ALLOW_SPACE = 1,
    parameter int         EARLY_ABORT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       en,
    input  logic       pt_wren,
    input  logic [7:0] pt_addr,
    input  logic [7:0] pt_wrdata,
    output logic       invalid,
    output logic       abort
);

    logic hit;

    assign hit = en && pt_wren && (pt_addr != LEN_ADDR)
              && is_bad_byte(pt_wrdata, CHAR_LO, CHAR_HI,
                             ALLOW_SPACE != 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            invalid <= 1'b0;
            abort   <= 1'b0;
        end else begin
            abort <= 1'b0;
            if (start) begin
                invalid <= 1'b0;
            end else if (hit) begin
                invalid <= 1'b1;
                abort   <= (EARLY_ABORT != 0) && !invalid;
            end
        end
    end

endmodule

// File: rtl/arc4_crack_ctrl.sv
// Brute-force key search controller driving one ARC4 decrypt core.
// Walks base, base+stride, ... until a clean plaintext, stop or key-space end.
module arc4_crack_ctrl
    import arc4_crack_pkg::*;
#(
    parameter int         KEY_W       = 24,
    parameter logic [7:0] CHAR_LO     = 8'd97,
    parameter logic [7:0] CHAR_HI     = 8'd122,
    parameter int         ALLOW_SPACE = 1,
    parameter int         EARLY_ABORT = 1,
    parameter int         CNT_W       = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    output logic             ready,
    input  logic [KEY_W-1:0] key_base,
    input  logic [KEY_W-1:0] key_stride,
    input  logic             stop,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic [CNT_W-1:0] tried,
    output logic             arc_valid,
    input  logic             arc_ready,
    output logic             arc_abort,
    input  logic             pt_wren,
    input  logic [7:0]       pt_addr,
    input  logic [7:0]       pt_wrdata
);

    crack_state_t     state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] stride_q, stride_d;
    logic             kv_q, kv_d;
    logic [CNT_W-1:0] tried_q, tried_d;
    logic             av_q, av_d;
    logic             start;
    logic             invalid;
    logic [KEY_W:0]   next_key;

    // Carry out of this sum means the next candidate would wrap.
    assign next_key = {1'b0, key_q} + {1'b0, stride_q};

    arc4_pt_checker #(
        .CHAR_LO     (CHAR_LO),
        .CHAR_HI     (CHAR_HI),
        .ALLOW_SPACE (ALLOW_SPACE),
        .EARLY_ABORT (EARLY_ABORT)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .en        (state_q == S_RUN),
        .pt_wren   (pt_wren),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .invalid   (invalid),
        .abort     (arc_abort)
    );

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        stride_d = stride_q;
        kv_d     = kv_q;
        tried_d  = tried_q;
        av_d     = 1'b0;
        start    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (valid) begin
                    key_d    = key_base;
                    stride_d = (key_stride == '0) ? KEY_W'(1)
                                                  : key_stride;
                    kv_d     = 1'b0;
                    tried_d  = '0;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (arc_ready) begin
                    av_d    = 1'b1;
                    start   = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // av_q marks the first RUN cycle; core ready is stale then.
                if (!av_q && arc_ready) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!(&tried_q)) begin
                    tried_d = tried_q + CNT_W'(1);
                end
                if (!invalid) begin
                    kv_d    = 1'b1;
                    state_d = S_IDLE;
                end else if (stop || next_key[KEY_W]) begin
                    state_d = S_IDLE;
                end else begin
                    key_d   = next_key[KEY_W-1:0];
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            stride_q <= '0;
            kv_q     <= 1'b0;
            tried_q  <= '0;
            av_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            stride_q <= stride_d;
            kv_q     <= kv_d;
            tried_q  <= tried_d;
            av_q     <= av_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign key       = key_q;
    assign key_valid = kv_q;
    assign tried     = tried_q;
    assign arc_valid = av_q;

endmodule

// File: tb/tb_arc4_crack_ctrl.sv
// Randomised bench for arc4_crack_ctrl with a behavioural ARC4 core stub.
// Search outcomes are predicted by walking the key sequence directly.
module tb_arc4_crack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [23:0] key_base;
    logic [23:0] key_stride;
    logic        stop;
    logic [23:0] key;
    logic        key_valid;
    logic [23:0] tried;
    logic        arc_valid;
    logic        arc_ready;
    logic        arc_abort;
    logic        pt_wren;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_wrdata;

    int n_cmp = 0;
    int n_bad = 0;
    int tot_av = 0;
    int tot_ab = 0;

    bit          good [logic [23:0]];
    bit          hello_en = 1'b0;
    logic [23:0] hello_key = '0;
    bit          fb_en = 1'b0;
    logic [23:0] fb_key = '0;
    logic [7:0]  len_data = 8'd5;
    int          seed = 0;

    logic [23:0] cur_key;
    int          phase;

    arc4_crack_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .ready      (ready),
        .key_base   (key_base),
        .key_stride (key_stride),
        .stop       (stop),
        .key        (key),
        .key_valid  (key_valid),
        .tried      (tried),
        .arc_valid  (arc_valid),
        .arc_ready  (arc_ready),
        .arc_abort  (arc_abort),
        .pt_wren    (pt_wren),
        .pt_addr    (pt_addr),
        .pt_wrdata  (pt_wrdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bad_sel(input int i);
        case (i)
            0: return 8'h60;
            1: return 8'h7B;
            2: return 8'h41;
            3: return 8'h00;
            4: return 8'hFF;
            5: return 8'h1F;
            default: return 8'h21;
        endcase
    endfunction

    // Plaintext byte a (1..5) that the stub core emits for key k.
    function automatic logic [7:0] pt_byte(input logic [23:0] k,
                                           input int a);
        int h;
        int p;
        string s;
        h = (int'(k) * 7 + a * 13 + seed) & 32'h7fffffff;
        p = 1 + ((int'(k) + seed) % 5);
        if (hello_en && k == hello_key) begin
            s = "hello";
            return s[a-1];
        end
        if (!good.exists(k)) begin
            if (fb_en && k == fb_key) begin
                if (a == 1) return 8'h41;
            end else if (a == p) begin
                return bad_sel(h % 7);
            end
        end
        if (h % 9 == 0) return 8'd32;
        return 8'(97 + h % 26);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            arc_ready <= 1'b1;
            pt_wren   <= 1'b0;
            pt_addr   <= '0;
            pt_wrdata <= '0;
            phase     <= 0;
            cur_key   <= '0;
        end else begin
            pt_wren <= 1'b0;
            if (arc_ready) begin
                if (arc_valid) begin
                    arc_ready <= 1'b0;
                    cur_key   <= key;
                    phase     <= 0;
                end
            end else if (arc_abort || phase == 6) begin
                arc_ready <= 1'b1;
            end else begin
                pt_wren   <= 1'b1;
                pt_addr   <= 8'(phase);
                pt_wrdata <= (phase == 0) ? len_data
                                          : pt_byte(cur_key, phase);
                phase     <= phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (arc_valid) tot_av <= tot_av + 1;
            if (arc_abort) tot_ab <= tot_ab + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [23:0] base,
                         input logic [23:0] stride,
                         input int stop_at,
                         output logic [23:0] ek, output bit ekv,
                         output int et, output int enb);
        longint s;
        s = (stride == 0) ? 1 : longint'(stride);
        ek = base;
        ekv = 1'b0;
        et = 0;
        enb = 0;
        for (int i = 0; i < 100000; i++) begin
            et++;
            if (good.exists(ek)) begin
                ekv = 1'b1;
                return;
            end
            enb++;
            if (stop_at != 0 && et >= stop_at) return;
            if (longint'(ek) + s > 64'hFFFFFF) return;
            ek = 24'(longint'(ek) + s);
        end
    endtask

    task automatic search(input logic [23:0] base,
                          input logic [23:0] stride,
                          input int stop_at, input bit hold);
        logic [23:0] ek;
        bit ekv;
        int et, enb, cyc, av0, ab0;
        model(base, stride, stop_at, ek, ekv, et, enb);
        @(posedge clk); #1;
        chk("idle_ready", ready, 1);
        av0 = tot_av;
        ab0 = tot_ab;
        key_base = base;
        key_stride = stride;
        valid = 1'b1;
        @(posedge clk); #1;
        chk("start_ready", ready, 0);
        chk("lat1", arc_valid, 0);
        if (hold) key_base = ~base;
        else valid = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0;
        chk("lat2", arc_valid, 1);
        cyc = 0;
        while (!ready && cyc < 3000) begin
            if (stop_at != 0 && tot_av - av0 >= stop_at) stop = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        stop = 1'b0;
        if (cyc >= 3000) chk("timeout", 1, 0);
        chk("key", key, ek);
        chk("key_valid", key_valid, ekv);
        chk("tried", tried, et);
        chk("n_arc_valid", tot_av - av0, et);
        chk("n_arc_abort", tot_ab - ab0, enb);
    endtask

    initial begin
        logic [23:0] b, s, gk;
        int g, sa;
        rst = 1'b1;
        valid = 1'b0;
        stop = 1'b0;
        key_base = '0;
        key_stride = '0;
        seed = int'($urandom & 32'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_key", key, 0);
        chk("rst_kv", key_valid, 0);
        chk("rst_tried", tried, 0);
        chk("rst_av", arc_valid, 0);
        chk("rst_ab", arc_abort, 0);
        rst = 1'b0;

        good.delete();
        good[24'h3] = 1'b1;
        hello_en = 1'b1;
        hello_key = 24'h3;
        search(24'h0, 24'h1, 0, 1'b0);
        hello_en = 1'b0;

        good.delete();
        fb_en = 1'b1;
        fb_key = 24'h100;
        good[24'h103] = 1'b1;
        search(24'h100, 24'h3, 0, 1'b0);
        fb_en = 1'b0;

        good.delete();
        search(24'hFFFFFC, 24'h2, 0, 1'b0);

        len_data = 8'hFF;
        good[24'h502] = 1'b1;
        search(24'h500, 24'h0, 0, 1'b0);
        len_data = 8'd5;

        good.delete();
        search(24'h200, 24'h1, 2, 1'b0);
        good[24'h301] = 1'b1;
        search(24'h300, 24'h1, 2, 1'b0);

        good[24'h402] = 1'b1;
        search(24'h400, 24'h1, 0, 1'b1);

        @(posedge clk); #1;
        key_base = 24'h10;
        key_stride = 24'h1;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_key", key, 0);
        chk("mid_rst_kv", key_valid, 0);
        chk("mid_rst_av", arc_valid, 0);
        chk("mid_rst_tried", tried, 0);

        for (int t = 0; t < 30; t++) begin
            good.delete();
            b = 24'($urandom);
            if (t % 4 == 3) b = 24'hFFFFFF - 24'($urandom_range(0, 12));
            s = 24'($urandom_range(0, 4));
            g = int'($urandom_range(0, 8));
            sa = ($urandom_range(0, 1) != 0)
                 ? int'($urandom_range(1, 9)) : 0;
            if (g != 0) begin
                if (longint'(b) + longint'(g - 1) *
                    ((s == 0) ? 1 : longint'(s)) <= 64'hFFFFFF) begin
                    gk = 24'(longint'(b) + longint'(g - 1) *
                             ((s == 0) ? 1 : longint'(s)));
                    good[gk] = 1'b1;
                end
            end
            if (good.num() == 0 && sa == 0 && t % 4 != 3)
                sa = int'($urandom_range(1, 6));
            search(b, s, sa, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
